// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//
// Sequential restoring divider. It produces one quotient bit per clock from a
// single subtract-and-shift step datapath. The result is the unsigned quotient
// dividend/divisor, given as ARG_BIT_WIDTH integer bits followed by PRECISION
// fractional bits, together with the final partial remainder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request valid; operands are taken when start && in_ready
//   in_ready   high only while idle
//   dividend   unsigned dividend
//   divisor    unsigned divisor
//   out_valid  result valid; held until accepted
//   out_ready  consumer accepts the result when out_valid && out_ready
//   q_int      integer quotient
//   q_frac     fractional quotient; the MSB has weight 2^-1
//   remainder  final partial remainder, scaled by 2^-PRECISION
//   div_zero   the divisor of this result was zero
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int ARG_BIT_WIDTH = 32,
  parameter int PRECISION     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     in_ready,
  input  logic [ARG_BIT_WIDTH-1:0] dividend,
  input  logic [ARG_BIT_WIDTH-1:0] divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ARG_BIT_WIDTH-1:0] q_int,
  output logic [PRECISION-1:0]     q_frac,
  output logic [ARG_BIT_WIDTH-1:0] remainder,
  output logic                     div_zero
);

  localparam int QW    = ARG_BIT_WIDTH + PRECISION;
  localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  logic [ARG_BIT_WIDTH-1:0] div_q;
  logic [ARG_BIT_WIDTH-1:0] dvd_sh;
  // The partial remainder always stays below the divisor after a step, so
  // only the low ARG_BIT_WIDTH bits of R are ever non-zero and are stored.
  logic [ARG_BIT_WIDTH-1:0] r;
  logic [CNT_W-1:0]         cnt;
  logic [QW-1:0]            q;
  logic                     dz;

  logic                     accept;
  logic [ARG_BIT_WIDTH:0]   t;
  logic                     ge;
  logic [ARG_BIT_WIDTH-1:0] r_step;

  assign accept = (state == IDLE) && start;

  // One restoring step. The compare uses the full ARG_BIT_WIDTH+1 bit trial
  // value. When it succeeds the difference is below the divisor, so the
  // subtraction can be done at ARG_BIT_WIDTH bits without losing anything.
  // Once all dividend bits have been shifted out, dvd_sh is zero, so the
  // shift-in bit automatically becomes 0 for the fractional steps.
  always_comb begin
    t      = {r, dvd_sh[ARG_BIT_WIDTH-1]};
    ge     = (t >= {1'b0, div_q});
    r_step = ge ? (t[ARG_BIT_WIDTH-1:0] - div_q) : t[ARG_BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        if (cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      dvd_sh <= '0;
      r      <= '0;
      cnt    <= '0;
      q      <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      div_q  <= divisor;
      dvd_sh <= dividend;
      cnt    <= '0;
      if (divisor == '0) begin
        // Saturated quotient; the dividend is returned unchanged as remainder.
        dz <= 1'b1;
        q  <= '1;
        r  <= dividend;
      end else begin
        dz <= 1'b0;
        r  <= '0;
      end
    end else if (state == ITER) begin
      dvd_sh <= {dvd_sh[ARG_BIT_WIDTH-2:0], 1'b0};
      r      <= r_step;
      q      <= {q[QW-2:0], ge};
      cnt    <= cnt + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q_int     = q[QW-1:PRECISION];
  assign q_frac    = q[PRECISION-1:0];
  assign remainder = r;
  assign div_zero  = dz;

endmodule
